// File: rtl/tinker_mem_ctrl.sv
// rtl/tinker_mem_ctrl.sv - two-port (fetch/data) arbitrated byte-array memory controller with fixed latency
module tinker_mem_ctrl #(
    parameter int MEM_BYTES = 524288,
    parameter int LATENCY   = 2,
    parameter int ADDR_W    = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              f_req_valid,
    output logic              f_req_ready,
    input  logic [ADDR_W-1:0] f_req_addr,
    output logic              f_rsp_valid,
    input  logic              f_rsp_ready,
    output logic [31:0]       f_rsp_data,
    output logic              f_rsp_err,
    input  logic              d_req_valid,
    output logic              d_req_ready,
    input  logic              d_req_we,
    input  logic [1:0]        d_req_size,
    input  logic [ADDR_W-1:0] d_req_addr,
    input  logic [63:0]       d_req_wdata,
    output logic              d_rsp_valid,
    input  logic              d_rsp_ready,
    output logic [63:0]       d_rsp_rdata,
    output logic              d_rsp_err,
    output logic              busy
);
    localparam int IDX_W = $clog2(MEM_BYTES);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam logic CH_FETCH = 1'b0;
    localparam logic CH_DATA  = 1'b1;

    logic [7:0] mem [MEM_BYTES];

    logic [1:0]        state;
    logic [3:0]        cnt;
    logic              last_grant;
    logic              lat_ch;
    logic              lat_we;
    logic [1:0]        lat_size;
    logic [ADDR_W-1:0] lat_addr;
    logic [63:0]       lat_wdata;
    logic              rsp_ch;
    logic [63:0]       rsp_data;
    logic              rsp_err;

    logic              grant_f;
    logic              grant_d;
    logic              idle_ok;
    logic              accept;
    logic              enter_resp;
    logic              rsp_hs;
    logic              cur_ch;
    logic              cur_we;
    logic [1:0]        cur_size;
    logic [ADDR_W-1:0] cur_addr;
    logic [63:0]       cur_wdata;
    logic [3:0]        nbytes;
    logic [7:0]        byte_en;
    logic [ADDR_W-1:0] limit;
    logic              cur_err;
    logic [63:0]       rd_data;

    // On contention the channel that did not win last time gets the grant.
    always_comb begin
        grant_d = d_req_valid && (!f_req_valid || (last_grant == CH_FETCH));
        grant_f = f_req_valid && !grant_d;
    end

    assign idle_ok     = (state == ST_IDLE) && reset;
    assign f_req_ready = idle_ok && grant_f;
    assign d_req_ready = idle_ok && grant_d;
    assign accept      = idle_ok && (grant_f || grant_d);

    // With LATENCY==1 the array is touched on the accept edge, so the live request is used directly.
    always_comb begin
        if (state == ST_IDLE) begin
            cur_ch    = grant_d ? CH_DATA : CH_FETCH;
            cur_we    = grant_d && d_req_we;
            cur_size  = grant_d ? d_req_size : 2'd2;
            cur_addr  = grant_d ? d_req_addr : f_req_addr;
            cur_wdata = d_req_wdata;
        end else begin
            cur_ch    = lat_ch;
            cur_we    = lat_we;
            cur_size  = lat_size;
            cur_addr  = lat_addr;
            cur_wdata = lat_wdata;
        end
    end

    assign nbytes     = 4'd1 << cur_size;
    assign byte_en    = 8'((9'd1 << nbytes) - 9'd1);
    assign limit      = ADDR_W'(MEM_BYTES) - ADDR_W'(nbytes);
    assign cur_err    = cur_addr > limit;
    assign enter_resp = ((state == ST_IDLE) && accept && (LATENCY == 1)) ||
                        ((state == ST_WAIT) && (cnt == 4'd1));

    always_comb begin
        rd_data = '0;
        for (int i = 0; i < 8; i++) begin
            if (byte_en[i] && !cur_err) begin
                rd_data[8*i +: 8] = mem[cur_addr[IDX_W-1:0] + IDX_W'(i)];
            end
        end
    end

    // Array has no reset so its contents survive a controller reset.
    always_ff @(posedge clk) begin
        if (reset && enter_resp && cur_we && !cur_err) begin
            for (int i = 0; i < 8; i++) begin
                if (byte_en[i]) begin
                    mem[cur_addr[IDX_W-1:0] + IDX_W'(i)] <= cur_wdata[8*i +: 8];
                end
            end
        end
    end

    assign rsp_hs = (state == ST_RESP) && ((rsp_ch == CH_DATA) ? d_rsp_ready : f_rsp_ready);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= ST_IDLE;
            cnt        <= 4'd0;
            last_grant <= CH_FETCH;
            lat_ch     <= CH_FETCH;
            lat_we     <= 1'b0;
            lat_size   <= 2'd0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            rsp_ch     <= CH_FETCH;
            rsp_data   <= '0;
            rsp_err    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        lat_ch     <= cur_ch;
                        lat_we     <= cur_we;
                        lat_size   <= cur_size;
                        lat_addr   <= cur_addr;
                        lat_wdata  <= cur_wdata;
                        last_grant <= cur_ch;
                        if (LATENCY > 1) begin
                            state <= ST_WAIT;
                            cnt   <= 4'(LATENCY - 1);
                        end else begin
                            state <= ST_RESP;
                        end
                    end
                end
                ST_WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (rsp_hs) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
            if (enter_resp) begin
                rsp_ch   <= cur_ch;
                rsp_data <= cur_we ? 64'd0 : rd_data;
                rsp_err  <= cur_err;
            end
        end
    end

    assign f_rsp_valid = (state == ST_RESP) && (rsp_ch == CH_FETCH);
    assign d_rsp_valid = (state == ST_RESP) && (rsp_ch == CH_DATA);
    assign f_rsp_data  = (rsp_ch == CH_FETCH) ? rsp_data[31:0] : 32'd0;
    assign f_rsp_err   = (rsp_ch == CH_FETCH) && rsp_err;
    assign d_rsp_rdata = (rsp_ch == CH_DATA) ? rsp_data : 64'd0;
    assign d_rsp_err   = (rsp_ch == CH_DATA) && rsp_err;
    assign busy        = (state != ST_IDLE);

endmodule

// File: doc/tinker_mem_ctrl.md
TINKER_MEM_CTRL -- requirements
Module: tinker_mem_ctrl

Interface
REQ-001 Parameter MEM_BYTES, default 524288: byte capacity of the internal array, addresses 0..MEM_BYTES-1.
REQ-002 Parameter LATENCY, default 2: cycles from request accept to response valid; legal range 1..15.
REQ-003 Parameter ADDR_W, default 64: width of both address buses.
REQ-004 clk  in  1  sole clock; all state changes on its rising edge.
REQ-005 reset  in  1  synchronous, active-low reset; 0 = reset asserted, sampled on rising clk.
REQ-006 f_req_valid  in  1  fetch request present.
REQ-007 f_req_ready  out  1  fetch request accepted this cycle when high with f_req_valid.
REQ-008 f_req_addr  in  ADDR_W  fetch byte address.
REQ-009 f_rsp_valid / f_rsp_ready  out / in  1 each  fetch response handshake.
REQ-010 f_rsp_data  out  32  instruction word, little-endian.
REQ-011 f_rsp_err  out  1  fetch address out of range.
REQ-012 d_req_valid / d_req_ready  in / out  1 each  data request handshake.
REQ-013 d_req_we  in  1  1 = store, 0 = load.
REQ-014 d_req_size  in  2  access size: 0=1B, 1=2B, 2=4B, 3=8B.
REQ-015 d_req_addr  in  ADDR_W  data byte address.
REQ-016 d_req_wdata  in  64  store data; low bytes used per size.
REQ-017 d_rsp_valid / d_rsp_ready  out / in  1 each  data response handshake.
REQ-018 d_rsp_rdata  out  64  load data, zero-extended; 0 for stores.
REQ-019 d_rsp_err  out  1  data access out of range.
REQ-020 busy  out  1  high in any state other than IDLE.

Function
REQ-021 FSM states: IDLE, WAIT, RESP; one request outstanding at a time.
REQ-022 IDLE: f_req_ready / d_req_ready equal the arbiter grant for that channel; both 0 outside IDLE.
REQ-023 Arbitration: single requester is granted; on contention, grant the channel not granted last; last_grant resets to FETCH, so data wins the first contention.
REQ-024 Accept (valid & ready in IDLE) latches channel, we, size, address, wdata, updates last_grant; next state WAIT if LATENCY>1, else RESP.
REQ-025 WAIT: counter decrements from LATENCY-1; leave to RESP on the edge completing LATENCY-1 WAIT cycles; rsp_valid first high exactly LATENCY cycles after the accept edge.
REQ-026 Array access (read sample or store commit) occurs on the edge entering RESP, little-endian, byte at addr = bits [7:0].
REQ-027 Range check: error when addr + nbytes > MEM_BYTES (nbytes = 4 for fetch, 1<<size for data), computed without overflow; on error no byte written, data outputs 0, err = 1.
REQ-028 Misaligned in-range accesses are legal and complete normally.
REQ-029 RESP: only the granted channel's rsp_valid is high; data and err held stable until rsp_ready; on valid & ready return to IDLE; new accept earliest the following cycle.
REQ-030 rsp_valid held indefinitely while rsp_ready = 0; request inputs ignored outside IDLE.
REQ-031 Store response: d_rsp_rdata = 0, d_rsp_err per REQ-027.

Reset
REQ-032 While reset = 0 at a rising edge: state IDLE, counter 0, last_grant FETCH, all rsp_valid 0, rsp data/err 0, busy 0.
REQ-033 Reset mid-operation (WAIT or RESP) abandons the request: no response issued; an uncommitted store is not written.
REQ-034 Array contents are not cleared by reset.
REQ-035 req_ready outputs are 0 during any cycle in which reset = 0.

Verification
REQ-036 Store 8B 0x1122334455667788 @0x100, then load 1B @0x103 -> d_rsp_rdata = 0x55, err 0; load 8B @0x100 -> full value.
REQ-037 Both valid in IDLE right after reset (LATENCY=2) -> data granted first, d_rsp_valid 2 cycles after accept; next contention -> fetch granted.
REQ-038 Fetch @MEM_BYTES-2 -> f_rsp_err = 1, f_rsp_data = 0; store 2B @MEM_BYTES-1 -> err = 1, byte MEM_BYTES-1 unchanged.
REQ-039 Hold d_rsp_ready = 0 for 5 cycles -> d_rsp_valid, data stable, both req_ready 0, busy 1; release -> IDLE next cycle.
REQ-040 Store accepted, reset asserted in WAIT -> no response; later load of same address returns prior contents.
REQ-041 LATENCY=1 build: fetch 0x2000 holding 0xDEADBEEF -> f_rsp_valid the cycle after accept, data 0xDEADBEEF.
